sll_seq: RTL

Multi-cycle logical left shifter for the RISC-V datapath. It implements the SLL/SLLI operation (rd = rs1 << rs2[4:0], zero fill) as a 5-stage logarithmic shift, performing one stage per clock behind a start/busy/done handshake. It is the left-direction counterpart of the combinational right shifter. It is intended for the multi-cycle execute path, where a full 32-bit barrel shifter in one cycle is too slow or too large.

---
 rtl/sll_seq.sv | 95 +++++++++
 1 files changed

// File: rtl/sll_seq.sv
// sll_seq: multi-cycle logical left shifter (SLL/SLLI).
// Applies one stage of a 5-stage logarithmic shift per clock (1, 2, 4, 8, 16)
// behind a start/busy/done handshake. With EARLY_EXIT=1 the sequence stops
// once no higher shift-amount bits remain set.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | applying stage k to acc each edge
// DONE  | one-cycle done pulse, rd_data valid
module sll_seq #(
  parameter int EARLY_EXIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [31:0] acc;
  logic [4:0]  amt;
  logic [2:0]  k;

  logic [4:0]  stage_sh;
  logic        amt_bit;
  logic        hi_clear;
  logic        last_stage;
  logic [31:0] stage_val;

  // Upper shift-amount bits are architecturally ignored.
  logic unused_rs2;
  assign unused_rs2 = ^rs2_data[31:5];

  // Result of the current stage and whether it is the final one.
  always_comb begin
    stage_sh   = 5'd1 << k;
    amt_bit    = |(amt & (5'd1 << k));
    stage_val  = amt_bit ? (acc << stage_sh) : acc;
    hi_clear   = (((amt >> k) >> 1) == 5'd0);
    last_stage = (k == 3'd4) || ((EARLY_EXIT != 0) && hi_clear);
  end

  // Sequencer: operand capture, per-stage shift, registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= 32'd0;
      amt     <= 5'd0;
      k       <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            acc   <= rs1_data;
            amt   <= rs2_data[4:0];
            k     <= 3'd0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= stage_val;
          if (last_stage) begin
            rd_data <= stage_val;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            k <= k + 3'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
